ocm_arbiter: RTL and testbench

- Shares one single-port on-chip memory (word-addressed, registered read data) between the instruction-fetch port and the load/store port.
- Arbitrates per cycle and drives the memory enable, byte-write, address and write-data lines.
- Tracks in-flight reads in a latency pipeline and steers read data back to the owning requester, in order.
- Sits between the core and the on-chip memory, replacing the two dedicated per-cache ports.

---
 rtl/ocm_pkg.sv | 20 ++
 rtl/ocm_rsp_pipe.sv | 52 +++++
 rtl/ocm_arbiter.sv | 105 ++++++++++
 tb/tb_ocm_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ocm_pkg.sv
// rtl/ocm_pkg.sv - shared types and limits for the on-chip memory arbiter
`ifndef XLEN
`define XLEN 32
`endif

package ocm_pkg;

  localparam int RD_LAT_MAX = 4;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

endpackage

// File: rtl/ocm_rsp_pipe.sv
// rtl/ocm_rsp_pipe.sv - in-flight read tag pipeline with fetch flush and response steering
`ifndef XLEN
`define XLEN 32
`endif

module ocm_rsp_pipe
  import ocm_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  owner_e            issue_owner,
  input  logic              flush,
  input  logic [`XLEN-1:0]  rdata,
  output logic              irsp_valid,
  output logic [`XLEN-1:0]  irsp_data,
  output logic              drsp_valid,
  output logic [`XLEN-1:0]  drsp_data
);

  tag_t stage_q [RD_LAT];
  tag_t resp;
  logic resp_live;

  // Shift tags one stage per cycle; a flush kills fetch-owned tags as they move
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '{valid: 1'b0, owner: OWN_I};
      end
    end else begin
      stage_q[0] <= '{valid: issue_valid, owner: issue_owner};
      for (int i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= '{valid: stage_q[i-1].valid & ~(flush & (stage_q[i-1].owner == OWN_I)),
                        owner: stage_q[i-1].owner};
      end
    end
  end

  // Last stage picks the owner; a same-cycle flush also suppresses a fetch response
  always_comb begin
    resp       = stage_q[RD_LAT-1];
    resp_live  = resp.valid & ~rst & ~(flush & (resp.owner == OWN_I));
    irsp_valid = resp_live & (resp.owner == OWN_I);
    drsp_valid = resp_live & (resp.owner == OWN_D);
    irsp_data  = irsp_valid ? rdata : '0;
    drsp_data  = drsp_valid ? rdata : '0;
  end

endmodule

// File: rtl/ocm_arbiter.sv
// rtl/ocm_arbiter.sv - fetch/load-store arbiter for one single-port OCM (OCM_ARB_RR_EN selects round-robin)
`ifndef XLEN
`define XLEN 32
`endif

module ocm_arbiter
  import ocm_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = `XLEN - 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ireq_valid_i,
  output logic                 ireq_ready_o,
  input  logic [`XLEN-1:0]     ireq_addr_i,
  input  logic                 iflush_i,
  output logic                 irsp_valid_o,
  output logic [`XLEN-1:0]     irsp_data_o,
  input  logic                 dreq_valid_i,
  output logic                 dreq_ready_o,
  input  logic                 dreq_we_i,
  input  logic [`XLEN/8-1:0]   dreq_be_i,
  input  logic [`XLEN-1:0]     dreq_addr_i,
  input  logic [`XLEN-1:0]     dreq_wdata_i,
  output logic                 drsp_valid_o,
  output logic [`XLEN-1:0]     drsp_data_o,
  output logic                 mem_en_o,
  output logic [`XLEN/8-1:0]   mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [`XLEN-1:0]     mem_wdata_o,
  input  logic [`XLEN-1:0]     mem_rdata_i
);

  logic grant_i;
  logic grant_d;

`ifdef OCM_ARB_RR_EN
  owner_e prio_q;

  // Priority pointer moves to the loser only when both ports competed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= OWN_D;
    end else if (ireq_valid_i && dreq_valid_i) begin
      prio_q <= grant_d ? OWN_I : OWN_D;
    end
  end

  // Round-robin grant; a sole requester always wins
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (!rst_i) begin
      if (dreq_valid_i && (!ireq_valid_i || prio_q == OWN_D)) begin
        grant_d = 1'b1;
      end else if (ireq_valid_i) begin
        grant_i = 1'b1;
      end
    end
  end
`else
  // Fixed priority: the data port always wins
  always_comb begin
    grant_d = ~rst_i & dreq_valid_i;
    grant_i = ~rst_i & ireq_valid_i & ~dreq_valid_i;
  end
`endif

  // Drive the memory from the granted port; byte writes only for a granted store
  always_comb begin
    mem_en_o    = grant_i | grant_d;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant_d) begin
      mem_addr_o = ADDR_W'(dreq_addr_i >> 2);
      if (dreq_we_i) begin
        mem_we_o    = dreq_be_i;
        mem_wdata_o = dreq_wdata_i;
      end
    end else if (grant_i) begin
      mem_addr_o = ADDR_W'(ireq_addr_i >> 2);
    end
  end

  assign ireq_ready_o = ireq_valid_i & grant_i;
  assign dreq_ready_o = dreq_valid_i & grant_d;

  ocm_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk         (clk_i),
    .rst         (rst_i),
    .issue_valid (grant_i | (grant_d & ~dreq_we_i)),
    .issue_owner (grant_d ? OWN_D : OWN_I),
    .flush       (iflush_i),
    .rdata       (mem_rdata_i),
    .irsp_valid  (irsp_valid_o),
    .irsp_data   (irsp_data_o),
    .drsp_valid  (drsp_valid_o),
    .drsp_data   (drsp_data_o)
  );

endmodule

// File: tb/tb_ocm_arbiter.sv
// tb/tb_ocm_arbiter.sv - randomized self-checking bench for ocm_arbiter against a behavioural model
`ifndef XLEN
`define XLEN 32
`endif

module tb_ocm_arbiter;

  localparam int RD_LAT = 2;
  localparam int XL     = `XLEN;
  localparam int AW     = XL - 2;
  localparam int NW     = 64;
  localparam int NS     = 256;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            ireq_valid_i;
  logic            ireq_ready_o;
  logic [XL-1:0]   ireq_addr_i;
  logic            iflush_i;
  logic            irsp_valid_o;
  logic [XL-1:0]   irsp_data_o;
  logic            dreq_valid_i;
  logic            dreq_ready_o;
  logic            dreq_we_i;
  logic [XL/8-1:0] dreq_be_i;
  logic [XL-1:0]   dreq_addr_i;
  logic [XL-1:0]   dreq_wdata_i;
  logic            drsp_valid_o;
  logic [XL-1:0]   drsp_data_o;
  logic            mem_en_o;
  logic [XL/8-1:0] mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [XL-1:0]   mem_wdata_o;
  logic [XL-1:0]   mem_rdata_i;

  always #5 clk = ~clk;

  ocm_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(AW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .ireq_valid_i (ireq_valid_i),
    .ireq_ready_o (ireq_ready_o),
    .ireq_addr_i  (ireq_addr_i),
    .iflush_i     (iflush_i),
    .irsp_valid_o (irsp_valid_o),
    .irsp_data_o  (irsp_data_o),
    .dreq_valid_i (dreq_valid_i),
    .dreq_ready_o (dreq_ready_o),
    .dreq_we_i    (dreq_we_i),
    .dreq_be_i    (dreq_be_i),
    .dreq_addr_i  (dreq_addr_i),
    .dreq_wdata_i (dreq_wdata_i),
    .drsp_valid_o (drsp_valid_o),
    .drsp_data_o  (drsp_data_o),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  // environment memory (driven by DUT outputs) and reference memory (driven by the model)
  logic [XL-1:0] env_mem [NW];
  logic [XL-1:0] ref_mem [NW];
  logic          env_v   [NS];
  logic [XL-1:0] env_d   [NS];
  // expected responses indexed by absolute cycle
  logic          exp_v   [NS];
  logic          exp_o   [NS];
  logic [XL-1:0] exp_d   [NS];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit ptr_d = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [XL-1:0] merge(input logic [XL-1:0] old, input logic [XL-1:0] wd,
                                          input logic [XL/8-1:0] be);
    logic [XL-1:0] r;
    r = old;
    for (int b = 0; b < XL/8; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic step(input logic r, input logic iv, input logic [XL-1:0] ia, input logic fl,
                      input logic dv, input logic dwe, input logic [XL/8-1:0] dbe,
                      input logic [XL-1:0] da, input logic [XL-1:0] dwd);
    bit gi, gd, ev, eo;
    logic [XL-1:0] ed;
    logic [XL-1:0] ga;
    int slot, idx;
    @(negedge clk);
    rst_i = r; ireq_valid_i = iv; ireq_addr_i = ia; iflush_i = fl;
    dreq_valid_i = dv; dreq_we_i = dwe; dreq_be_i = dbe; dreq_addr_i = da; dreq_wdata_i = dwd;
    slot = cyc % NS;
    mem_rdata_i = env_v[slot] ? env_d[slot] : XL'($urandom);
    env_v[slot] = 1'b0;
    #1;
    gi = 1'b0; gd = 1'b0;
    if (r) begin
      for (int k = 0; k <= RD_LAT; k++) exp_v[(cyc + k) % NS] = 1'b0;
      ptr_d = 1'b1;
    end else begin
      if (fl) for (int k = 0; k < RD_LAT; k++)
        if (exp_v[(cyc + k) % NS] && !exp_o[(cyc + k) % NS]) exp_v[(cyc + k) % NS] = 1'b0;
`ifdef OCM_ARB_RR_EN
      gd = dv && (!iv || ptr_d);
      gi = iv && !gd;
      if (iv && dv) ptr_d = !gd;
`else
      gd = dv;
      gi = iv && !dv;
`endif
    end
    ev = exp_v[slot]; eo = exp_o[slot]; ed = exp_d[slot];
    ga = gd ? da : ia;
    chk("ireq_ready", 64'(ireq_ready_o), 64'(gi));
    chk("dreq_ready", 64'(dreq_ready_o), 64'(gd));
    chk("mem_en",     64'(mem_en_o),     64'(gi | gd));
    chk("mem_we",     64'(mem_we_o),     64'((gd && dwe) ? dbe : '0));
    if (gi || gd) chk("mem_addr", 64'(mem_addr_o), 64'(AW'(ga >> 2)));
    if (gd && dwe) chk("mem_wdata", 64'(mem_wdata_o), 64'(dwd));
    if (r) begin
      chk("rst_mem_addr",  64'(mem_addr_o),  64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
    end
    chk("irsp_valid", 64'(irsp_valid_o), 64'(ev && !eo));
    chk("irsp_data",  64'(irsp_data_o),  64'((ev && !eo) ? ed : '0));
    chk("drsp_valid", 64'(drsp_valid_o), 64'(ev && eo));
    chk("drsp_data",  64'(drsp_data_o),  64'((ev && eo) ? ed : '0));
    exp_v[slot] = 1'b0;
    if (gi || gd) begin
      idx = int'((ga >> 2) % NW);
      if (gd && dwe) ref_mem[idx] = merge(ref_mem[idx], dwd, dbe);
      else begin
        exp_v[(cyc + RD_LAT) % NS] = 1'b1;
        exp_o[(cyc + RD_LAT) % NS] = gd;
        exp_d[(cyc + RD_LAT) % NS] = ref_mem[idx];
      end
    end
    if (mem_en_o) begin
      idx = int'(mem_addr_o % NW);
      if (mem_we_o == '0) begin
        env_v[(cyc + RD_LAT) % NS] = 1'b1;
        env_d[(cyc + RD_LAT) % NS] = env_mem[idx];
      end else begin
        env_mem[idx] = merge(env_mem[idx], mem_wdata_o, mem_we_o);
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    rst_i = 1'b1; ireq_valid_i = 1'b0; ireq_addr_i = '0; iflush_i = 1'b0;
    dreq_valid_i = 1'b0; dreq_we_i = 1'b0; dreq_be_i = '0; dreq_addr_i = '0; dreq_wdata_i = '0;
    mem_rdata_i = '0;
    for (int i = 0; i < NW; i++) begin
      env_mem[i] = XL'($urandom);
      ref_mem[i] = env_mem[i];
    end
    env_mem[4] = 32'h0000_0013;  ref_mem[4] = 32'h0000_0013;
    env_mem[32] = '0;            ref_mem[32] = '0;
    for (int i = 0; i < NS; i++) begin
      env_v[i] = 1'b0; exp_v[i] = 1'b0; exp_o[i] = 1'b0; exp_d[i] = '0; env_d[i] = '0;
    end

    // reset with both ports requesting: nothing may be granted
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, '0, 32'h40, '0);
    chk("lit_rst_ready", 64'({ireq_ready_o, dreq_ready_o, mem_en_o}), 64'(0));
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // single fetch of word 4
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("lit_fetch_en",   64'(mem_en_o),   64'(1));
    chk("lit_fetch_addr", 64'(mem_addr_o), 64'(4));
    idle();
    idle();
    chk("lit_fetch_rsp",  64'({irsp_valid_o, drsp_valid_o, irsp_data_o}), {31'd0, 1'b1, 1'b0, 32'h0000_0013});

    // simultaneous fetch and load: load first
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, '0, 32'h40, '0);
    chk("lit_both_ready", 64'({dreq_ready_o, ireq_ready_o}), 64'(2'b10));
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("lit_fetch_next", 64'(ireq_ready_o), 64'(1));
    idle();
    chk("lit_drsp_first", 64'({drsp_valid_o, irsp_valid_o}), 64'(2'b10));
    idle();
    chk("lit_irsp_second", 64'({drsp_valid_o, irsp_valid_o}), 64'(2'b01));

    // partial store then load of the same word
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h80, 32'hDEAD_BEEF);
    chk("lit_store_we", 64'(mem_we_o), 64'(4'b0011));
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 32'h80, '0);
    idle();
    chk("lit_store_norsp", 64'({drsp_valid_o, irsp_valid_o}), 64'(0));
    idle();
    chk("lit_load_merge", 64'({drsp_valid_o, drsp_data_o}), {31'd0, 1'b1, 32'h0000_BEEF});

    // reset one cycle after a load issues
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 32'h40, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle();
    chk("lit_post_rst", 64'({drsp_valid_o, irsp_valid_o, mem_en_o, mem_we_o, dreq_ready_o, ireq_ready_o}), 64'(0));
    chk("lit_post_rst_data", 64'({drsp_data_o, irsp_data_o}), 64'(0));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, iv, fl, dv, dwe;
      logic [XL/8-1:0] dbe;
      r   = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 99) < 60);
      fl  = ($urandom_range(0, 9) == 0);
      dv  = ($urandom_range(0, 99) < 55);
      dwe = $urandom_range(0, 1) == 1;
      dbe = ($urandom_range(0, 7) == 0) ? '0 : (XL/8)'($urandom);
      step(r, iv, XL'($urandom_range(0, 255)), fl, dv, dwe, dbe,
           XL'($urandom_range(0, 255)), XL'($urandom));
    end
    for (int n = 0; n < RD_LAT + 1; n++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
